// File: rtl/tub_pwr_pkg.sv
// Shared definitions for the TUB rail sequencers: state encoding and fault codes.
// The encodings are visible on the debug STATE and FAULT_CODE readback ports.
package tub_pwr_pkg;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        RAMP   = 3'd1,
        SETTLE = 3'd2,
        ON     = 3'd3,
        FLT    = 3'd4
    } pwr_state_e;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_TIMEOUT  = 2'b01;
    localparam logic [1:0] FC_VEE_LOST = 2'b10;
    localparam logic [1:0] FC_VCC_LOST = 2'b11;

    // Regulator stays enabled while ramping, settling and on.
    function automatic logic reg_on(input pwr_state_e s);
        return (s == RAMP) || (s == SETTLE) || (s == ON);
    endfunction

endpackage

// File: rtl/tub_sync_debounce.sv
// Two-flop synchronizer followed by a glitch filter: the output takes a new
// level only after DEBOUNCE consecutive synchronized samples disagree with it.
module tub_sync_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic D_ASYNC,
    output logic Q
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic          meta_q;
    logic          sync_q;
    logic          filt_q;
    logic [CW-1:0] run_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            filt_q <= 1'b0;
            run_q  <= '0;
        end else begin
            meta_q <= D_ASYNC;
            sync_q <= meta_q;
            // Any sample agreeing with the filtered level restarts the run.
            if (sync_q != filt_q) begin
                if (run_q == CW'(DEBOUNCE - 1)) begin
                    filt_q <= sync_q;
                    run_q  <= '0;
                end else begin
                    run_q <= run_q + 1'b1;
                end
            end else begin
                run_q <= '0;
            end
        end
    end

    assign Q = filt_q;

endmodule

// File: rtl/vee_rail_sequencer.sv
// -5.2 V ECL rail sequencer: ramps the regulator, waits for a settled rail,
// releases ECL logic, and latches the first fault until acknowledged.
module vee_rail_sequencer #(
    parameter int DEBOUNCE      = 4,
    parameter int RAMP_TIMEOUT  = 1000,
    parameter int SETTLE_CYCLES = 256,
    parameter int CNT_W         = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE_REQ,
    input  logic       FAULT_CLR,
    input  logic       VCC_OK,
    input  logic       VEE_OK,
    output logic       REG_EN,
    output logic       ECL_EN,
    output logic       PWR_GOOD,
    output logic       FAULT,
    output logic [1:0] FAULT_CODE,
    output logic [2:0] STATE
);

    import tub_pwr_pkg::*;

    localparam logic [CNT_W-1:0] RAMP_LAST   = CNT_W'(RAMP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic vcc_f;
    logic vee_f;

    pwr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic             reg_en_q, ecl_en_q, pwr_good_q, fault_q;

    tub_sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_vcc_filt (
        .CLK     (CLK),
        .RESET   (RESET),
        .D_ASYNC (VCC_OK),
        .Q       (vcc_f)
    );

    tub_sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_vee_filt (
        .CLK     (CLK),
        .RESET   (RESET),
        .D_ASYNC (VEE_OK),
        .Q       (vee_f)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            OFF: begin
                if (ENABLE_REQ && vcc_f) state_d = RAMP;
            end
            RAMP: begin
                // A good rail arriving on the timeout cycle still counts as success.
                if (!vcc_f) begin
                    state_d = FLT;
                    code_d  = FC_VCC_LOST;
                end else if (vee_f) begin
                    state_d = ENABLE_REQ ? SETTLE : OFF;
                end else if (cnt_q == RAMP_LAST) begin
                    state_d = FLT;
                    code_d  = FC_TIMEOUT;
                end else if (!ENABLE_REQ) begin
                    state_d = OFF;
                end
            end
            SETTLE: begin
                if (!vcc_f) begin
                    state_d = FLT;
                    code_d  = FC_VCC_LOST;
                end else if (!vee_f) begin
                    state_d = FLT;
                    code_d  = FC_VEE_LOST;
                end else if (!ENABLE_REQ) begin
                    state_d = OFF;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ON;
                end
            end
            ON: begin
                if (!vcc_f) begin
                    state_d = FLT;
                    code_d  = FC_VCC_LOST;
                end else if (!vee_f) begin
                    state_d = FLT;
                    code_d  = FC_VEE_LOST;
                end else if (!ENABLE_REQ) begin
                    state_d = OFF;
                end
            end
            FLT: begin
                // Clearing needs the request withdrawn, so a fault never auto-restarts.
                if (FAULT_CLR && !ENABLE_REQ) begin
                    state_d = OFF;
                    code_d  = FC_NONE;
                end
            end
            default: begin
                state_d = OFF;
                code_d  = FC_NONE;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (((state_q == RAMP) || (state_q == SETTLE)) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs decode the next state so they move on the same edge as STATE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= OFF;
            cnt_q      <= '0;
            code_q     <= FC_NONE;
            reg_en_q   <= 1'b0;
            ecl_en_q   <= 1'b0;
            pwr_good_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            reg_en_q   <= reg_on(state_d);
            ecl_en_q   <= (state_d == ON);
            pwr_good_q <= (state_d == ON);
            fault_q    <= (state_d == FLT);
        end
    end

    assign REG_EN     = reg_en_q;
    assign ECL_EN     = ecl_en_q;
    assign PWR_GOOD   = pwr_good_q;
    assign FAULT      = fault_q;
    assign FAULT_CODE = code_q;
    assign STATE      = state_q;

endmodule

// File: tb/tb_vee_rail_sequencer.sv
// Directed-with-random-timing bench for the -5.2 V rail sequencer; expectations
// come from the published latencies and the per-state output table.
module tb_vee_rail_sequencer;

    localparam int DEB = 4;
    localparam int RT  = 1000;
    localparam int SC  = 256;
    localparam int LAT = 2 + DEB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic       vcc = 1'b0;
    logic       vee = 1'b0;
    logic       reg_en, ecl_en, pg, fault;
    logic [1:0] code;
    logic [2:0] st;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vee_rail_sequencer #(
        .DEBOUNCE      (DEB),
        .RAMP_TIMEOUT  (RT),
        .SETTLE_CYCLES (SC),
        .CNT_W         (16)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .ENABLE_REQ (en),
        .FAULT_CLR  (clr),
        .VCC_OK     (vcc),
        .VEE_OK     (vee),
        .REG_EN     (reg_en),
        .ECL_EN     (ecl_en),
        .PWR_GOOD   (pg),
        .FAULT      (fault),
        .FAULT_CODE (code),
        .STATE      (st)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Expected {REG_EN, ECL_EN, PWR_GOOD, FAULT} for each state.
    function automatic logic [3:0] exp_outs(input int s);
        case (s)
            1, 2:    return 4'b1000;
            3:       return 4'b1110;
            4:       return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check_all(input string tag, input int s, input int c);
        check({tag, "/state"}, 32'(st), 32'(s));
        check({tag, "/outs"}, 32'({reg_en, ecl_en, pg, fault}), 32'(exp_outs(s)));
        check({tag, "/code"}, 32'(code), 32'(c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until STATE == s; an expired budget is a failed comparison.
    task automatic wait_state(input int s, input int budget, output int n);
        bit hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < budget) begin
            tick();
            n++;
            if (st === 3'(s)) hit = 1'b1;
        end
        if (!hit) check("wait_state_timeout", 32'(st), 32'(s));
    endtask

    task automatic recover(input int c);
        en = 1'b0;
        tick();
        check_all("flt_hold", 4, c);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_all("flt_cleared", 0, 0);
    endtask

    task automatic power_up();
        int n;
        en = 1'b1;
        wait_state(3, 400, n);
        check("powerup_len", 32'(n), 32'(2 + SC));
        check_all("powerup_on", 3, 0);
    endtask

    initial begin
        int n, d, w;

        rst = 1'b1;
        repeat (3) tick();
        check_all("reset", 0, 0);
        #2 rst = 1'b0;
        tick();
        check_all("idle", 0, 0);

        // Normal power-up with a random regulator rise delay.
        vcc = 1'b1;
        en  = 1'b1;
        wait_state(1, 50, n);
        check("vcc_to_ramp", 32'(n), 32'(LAT));
        check_all("ramp", 1, 0);
        d = $urandom_range(20, 80);
        repeat (d) tick();
        vee = 1'b1;
        wait_state(2, 50, n);
        check("vee_to_settle", 32'(n), 32'(LAT));
        check_all("settle", 2, 0);
        wait_state(3, 400, n);
        check("settle_len", 32'(n), 32'(SC));
        check_all("on", 3, 0);

        // Short VEE dropouts must be filtered out.
        for (int i = 0; i < 6; i++) begin
            w = (i < 3) ? i + 1 : int'($urandom_range(1, 3));
            vee = 1'b0;
            repeat (w) tick();
            vee = 1'b1;
            repeat (12) tick();
            check_all("glitch_reject", 3, 0);
        end

        // A long dropout is a real loss.
        w = $urandom_range(5, 6);
        vee = 1'b0;
        n = 0;
        while (n < 30 && st !== 3'd4) begin
            tick();
            n++;
            if (n == w) vee = 1'b1;
        end
        vee = 1'b1;
        check("vee_loss_latency", 32'(n), 32'(LAT));
        check_all("vee_lost", 4, 2);
        repeat (LAT + 2) tick();
        recover(2);

        // Both rails collapse together: VCC loss takes priority.
        power_up();
        vcc = 1'b0;
        vee = 1'b0;
        wait_state(4, 20, n);
        check("dual_loss_latency", 32'(n), 32'(LAT));
        check_all("dual_loss", 4, 3);
        vcc = 1'b1;
        vee = 1'b1;
        repeat (LAT + 2) tick();
        check_all("dual_loss_no_overwrite", 4, 3);
        recover(3);

        // Orderly shutdown.
        power_up();
        repeat ($urandom_range(1, 30)) tick();
        en = 1'b0;
        tick();
        check_all("shutdown", 0, 0);

        // Ramp timeout with the regulator never reporting good.
        vee = 1'b0;
        repeat (LAT + 2) tick();
        en = 1'b1;
        wait_state(1, 5, n);
        check("ramp_entry", 32'(n), 32'(1));
        wait_state(4, 1100, n);
        check("ramp_timeout_len", 32'(n), 32'(RT));
        check_all("ramp_timeout", 4, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (5) tick();
        check_all("clr_ignored", 4, 1);
        recover(1);
        vee = 1'b1;
        repeat (LAT + 2) tick();

        // Asynchronous reset in the middle of SETTLE, then a clean restart.
        en = 1'b1;
        wait_state(2, 10, n);
        check("settle_entry", 32'(n), 32'(2));
        repeat ($urandom_range(10, 200)) tick();
        #2 rst = 1'b1;
        #1;
        check_all("async_reset", 0, 0);
        tick();
        #3 rst = 1'b0;
        wait_state(3, 400, n);
        check("restart_len", 32'(n), 32'(LAT + 1 + SC));
        check_all("restart_on", 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
